mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch path and the load/store data path of the RISC-V core. Requests use a req/gnt handshake. One transaction is outstanding at a time, and the memory read latency is fixed. Data accesses win by default. An optional starvation guard forces a fetch grant after a run of consecutive data grants. The block sits between the PC/instruction-fetch logic, the load/store unit and the memory macro.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range 1..15
- STARVE_MAX, 4, consecutive data grants tolerated while if_req is pending; guard builds only; legal range 1..15
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_gnt  out  1  one-cycle fetch grant pulse
- if_rvalid  out  1  one-cycle fetch data valid pulse
- if_rdata  out  DATA_W  fetch data; meaningful only when if_rvalid is high
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle data grant pulse
- d_rvalid  out  1  one-cycle completion pulse; for loads it carries the data
- d_rdata  out  DATA_W  load data; 0 for stores
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid MEM_LAT cycles after mem_en
- busy  out  1  high while a transaction is outstanding

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - No request pending: stay in IDLE.
  - Any request pending: arbitrate, grant, go to WAIT.
- **Arbitration**
  - d_req beats if_req.
  - Exception: with the guard active and starve_cnt == STARVE_MAX, fetch wins.
- **Grant cycle**
  - Winner's gnt = 1.
  - mem_en = 1.
  - mem_addr, mem_we and mem_wdata are driven combinationally from the winner's inputs.
  - mem_we = d_we for data, 0 for fetch.
  - Latency counter is loaded with MEM_LAT; the owner (fetch or data) is recorded.
- **WAIT**
  - Counter decrements each cycle.
  - On the cycle the counter reads 1, mem_rdata is registered into the owner's rdata and the state moves to RESP.
- **RESP**
  - Owner's rvalid = 1 for exactly this cycle.
  - Store completion: d_rvalid = 1 and d_rdata = 0.
  - Arbitration runs again in the same cycle. Any request pending: grant and go to WAIT (back-to-back). Otherwise go to IDLE.
- **busy**: high in WAIT and RESP; low in IDLE.
- **Ungranted requests**: a requester that drops req before gnt loses its request silently; no error is raised.
- **Unused outputs**: idle-cycle values of mem_addr and mem_wdata are 0.

## Timing
- **Reset values**: all outputs 0; state IDLE; counter 0; starve_cnt 0. if_rdata and d_rdata are cleared to 0.
- **Reset mid-transaction**: the outstanding access is abandoned. No rvalid is emitted for it. The first grant can occur in the first cycle with rst high.
- **Latency**: grant in cycle T, mem_rdata sampled at the end of cycle T+MEM_LAT, rvalid in cycle T+MEM_LAT+1.
- **Throughput**: one transaction per MEM_LAT+1 cycles under continuous load.
- **Simultaneous requests**: exactly one gnt per grant cycle. The loser keeps its req and is re-arbitrated in the next RESP or IDLE cycle.
- **starve_cnt update** (guard builds only, updated on each grant edge):
  - Incremented on a data grant while if_req is high; saturates at STARVE_MAX.
  - Cleared on a fetch grant, or in any cycle where if_req is low.

## Configuration
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: starve_cnt logic is built and the STARVE_MAX override is active.
- Undefined: no counter is built, and data always beats fetch (strict priority). STARVE_MAX is ignored.

## Test plan
- **Single fetch**, MEM_LAT=2: if_req, if_addr=0x10, memory word at 0x10 = 0x00C58533.
  - if_gnt and mem_en in cycle 0.
  - if_rvalid with if_rdata=0x00C58533 in cycle 3.
  - busy high in cycles 1-3.
- **Simultaneous requests**: if_req and d_req (load, addr 0x20) both rise in cycle 0.
  - d_gnt in cycle 0, d_rvalid in cycle 3.
  - if_gnt in cycle 3, if_rvalid in cycle 6.
- **Store then load**: store 0xDEADBEEF to 0x40, then load 0x40.
  - Store: mem_we=1 in its grant cycle; d_rvalid with d_rdata=0.
  - Load: d_rdata=0xDEADBEEF.
- **Starvation**, guard defined, STARVE_MAX=4: d_req held continuously and if_req held continuously.
  - Four d_gnts, then one if_gnt.
  - With the macro undefined: no if_gnt while d_req stays high.
- **Reset mid-op**: rst low in cycle 1 after a fetch grant in cycle 0.
  - No if_rvalid is ever emitted for that fetch.
  - All outputs are 0 in the cycle after the rst-low edge.
  - Re-grant occurs in the first cycle after rst returns high.
- **Idle**: no requests for 20 cycles.
  - mem_en, busy, both gnts and both rvalids stay 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and
// the load/store path. One transaction outstanding, fixed read latency MEM_LAT.
// Data wins arbitration by default. Optional macro MEM_ARB_STARVE_GUARD_EN builds a
// starvation counter that forces a fetch grant after STARVE_MAX consecutive data
// grants while a fetch is waiting.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    // instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    // load/store port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    // memory macro
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              owner_d_q;   // 1 = data path owns the outstanding access
    logic              owner_we_q;  // outstanding data access is a store
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic can_grant;
    logic fetch_wins;
    logic grant_f;
    logic grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_q;

    // Fetch wins when it is alone, or when it has been passed over STARVE_MAX times
    always_comb begin
        fetch_wins = if_req_i && (!d_req_i || (starve_q == 4'(STARVE_MAX)));
    end

    // Count consecutive data grants that bypassed a waiting fetch
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_q <= 4'd0;
        end else if (!if_req_i || grant_f) begin
            starve_q <= 4'd0;
        end else if (grant_d && (starve_q != 4'(STARVE_MAX))) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`else
    logic unused_starve_max;
    assign unused_starve_max = ^STARVE_MAX;

    // Strict priority: fetch only wins when data is not requesting
    always_comb begin
        fetch_wins = if_req_i && !d_req_i;
    end
`endif

    // Arbitrate in IDLE and RESP; grants are suppressed while reset is asserted
    always_comb begin
        can_grant = rst_ni && ((state_q == StIdle) || (state_q == StResp));
        grant_f   = can_grant && fetch_wins;
        grant_d   = can_grant && d_req_i && !fetch_wins;
    end

    // Grant-cycle memory strobes come straight from the winner's request inputs
    always_comb begin
        if_gnt_o    = grant_f;
        d_gnt_o     = grant_d;
        mem_en_o    = grant_f || grant_d;
        mem_we_o    = grant_d && d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant_d) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (grant_f) begin
            mem_addr_o  = if_addr_i;
        end
    end

    // Response strobes decode from the registered state; busy spans WAIT and RESP
    always_comb begin
        if_rvalid_o = rst_ni && (state_q == StResp) && !owner_d_q;
        d_rvalid_o  = rst_ni && (state_q == StResp) && owner_d_q;
        if_rdata_o  = if_rdata_q;
        d_rdata_o   = d_rdata_q;
        busy_o      = (state_q != StIdle);
    end

    // Transaction FSM: grant, count down the read latency, capture, respond
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            owner_d_q  <= 1'b0;
            owner_we_q <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle, StResp: begin
                    if (grant_f || grant_d) begin
                        state_q    <= StWait;
                        cnt_q      <= 4'(MEM_LAT);
                        owner_d_q  <= grant_d;
                        owner_we_q <= grant_d && d_we_i;
                    end else begin
                        state_q    <= StIdle;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                        if (owner_d_q) begin
                            d_rdata_q <= owner_we_q ? '0 : mem_rdata_i;
                        end else begin
                            if_rdata_q <= mem_rdata_i;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned LAT  = 2;
    localparam int unsigned SMAX = 4;
    localparam int          LOGN = 2048;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt, if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MEM_LAT   (LAT),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // memory contents as the model believes them to be
    logic [31:0] mem [logic [31:0]];

    // reference model: one in-flight transaction described by owner and response cycle
    bit          m_act = 1'b0;
    int          m_resp = 0;
    bit          m_own_d = 1'b0;
    logic [31:0] m_word = '0;
    logic [31:0] m_exp = '0;
    int          m_starve = 0;
    bit          m_gf = 1'b0, m_gd = 1'b0;
    bit          after_rst = 1'b0;
    bit          hold_d = 1'b0;

    // per-cycle observation log for directed cycle-accurate checks
    logic        lg_ifgnt [LOGN];
    logic        lg_dgnt  [LOGN];
    logic        lg_ifrv  [LOGN];
    logic        lg_drv   [LOGN];
    logic        lg_memen [LOGN];
    logic        lg_memwe [LOGN];
    logic        lg_busy  [LOGN];
    logic [31:0] lg_ifrd  [LOGN];
    logic [31:0] lg_drd   [LOGN];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5C3_0F00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive memory data, compare against the model, advance the model.
    task automatic tick();
        bit          free, fw, gf, gd, e_rvi, e_rvd;
        logic [31:0] e_addr, e_wdata;
        if (m_act && (cyc == m_resp - 1)) mem_rdata = m_word;
        else mem_rdata = $urandom;
        #1;
        free = !m_act || (cyc == m_resp);
        gf = 1'b0;
        gd = 1'b0;
        if (rst_n && free) begin
            fw = if_req && (!d_req || (GUARD && (m_starve == SMAX)));
            gf = fw;
            gd = d_req && !fw;
        end
        e_addr  = gd ? d_addr : (gf ? if_addr : 32'h0);
        e_wdata = gd ? d_wdata : 32'h0;
        e_rvi   = rst_n && m_act && (cyc == m_resp) && !m_own_d;
        e_rvd   = rst_n && m_act && (cyc == m_resp) && m_own_d;
        chk("if_gnt", 64'(if_gnt), 64'(gf));
        chk("d_gnt", 64'(d_gnt), 64'(gd));
        chk("mem_en", 64'(mem_en), 64'(gf | gd));
        chk("mem_we", 64'(mem_we), 64'(gd & d_we));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
        chk("if_rvalid", 64'(if_rvalid), 64'(e_rvi));
        chk("d_rvalid", 64'(d_rvalid), 64'(e_rvd));
        chk("busy", 64'(busy), 64'(m_act));
        if (e_rvi) chk("if_rdata", 64'(if_rdata), 64'(m_exp));
        if (e_rvd) chk("d_rdata", 64'(d_rdata), 64'(m_exp));
        if (after_rst) begin
            chk("if_rdata_rst", 64'(if_rdata), 64'h0);
            chk("d_rdata_rst", 64'(d_rdata), 64'h0);
        end
        if (cyc < LOGN) begin
            lg_ifgnt[cyc] = if_gnt;
            lg_dgnt[cyc]  = d_gnt;
            lg_ifrv[cyc]  = if_rvalid;
            lg_drv[cyc]   = d_rvalid;
            lg_memen[cyc] = mem_en;
            lg_memwe[cyc] = mem_we;
            lg_busy[cyc]  = busy;
            lg_ifrd[cyc]  = if_rdata;
            lg_drd[cyc]   = d_rdata;
        end
        if (!rst_n) begin
            m_act     = 1'b0;
            m_starve  = 0;
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            if (m_act && (cyc == m_resp)) m_act = 1'b0;
            if (gf || gd) begin
                m_act   = 1'b1;
                m_resp  = cyc + int'(LAT) + 1;
                m_own_d = gd;
                if (gd && d_we) begin
                    mem[d_addr] = d_wdata;
                    m_word      = d_wdata;
                    m_exp       = 32'h0;
                end else begin
                    m_word = mem_rd(gd ? d_addr : if_addr);
                    m_exp  = m_word;
                end
            end
            if (!if_req || gf) m_starve = 0;
            else if (gd && (m_starve < SMAX)) m_starve++;
        end
        m_gf = gf;
        m_gd = gd;
        @(negedge clk);
        cyc++;
    endtask

    // Requesters hold req until the model grants it, then drop it.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (m_gf) if_req = 1'b0;
            if (m_gd) begin
                if (hold_d) d_addr = 32'($urandom_range(0, 15) * 4);
                else d_req = 1'b0;
            end
        end
    endtask

    initial begin
        int c0, c1, nf;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem[32'h10] = 32'h00C5_8533;
        repeat (2) @(posedge clk);
        @(negedge clk);
        after_rst = 1'b1;

        // reset state
        run(2);

        // single fetch
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        c0 = cyc;
        run(5);
        chk("sf_if_gnt_c0", 64'(lg_ifgnt[c0]), 64'h1);
        chk("sf_mem_en_c0", 64'(lg_memen[c0]), 64'h1);
        chk("sf_busy_c0", 64'(lg_busy[c0]), 64'h0);
        for (int k = 1; k <= 3; k++) chk("sf_busy", 64'(lg_busy[c0 + k]), 64'h1);
        chk("sf_if_rvalid_c3", 64'(lg_ifrv[c0 + 3]), 64'h1);
        chk("sf_if_rdata_c3", 64'(lg_ifrd[c0 + 3]), 64'h00C5_8533);

        // simultaneous requests
        if_req  = 1'b1;
        if_addr = 32'h14;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h20;
        c0 = cyc;
        run(8);
        chk("sim_d_gnt_c0", 64'(lg_dgnt[c0]), 64'h1);
        chk("sim_if_gnt_c0", 64'(lg_ifgnt[c0]), 64'h0);
        chk("sim_d_rvalid_c3", 64'(lg_drv[c0 + 3]), 64'h1);
        chk("sim_if_gnt_c3", 64'(lg_ifgnt[c0 + 3]), 64'h1);
        chk("sim_if_rvalid_c6", 64'(lg_ifrv[c0 + 6]), 64'h1);

        // store then load
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'hDEAD_BEEF;
        c0 = cyc;
        run(4);
        d_req = 1'b1;
        d_we  = 1'b0;
        c1 = cyc;
        run(5);
        chk("st_mem_we", 64'(lg_memwe[c0]), 64'h1);
        chk("st_d_rvalid", 64'(lg_drv[c0 + 3]), 64'h1);
        chk("st_d_rdata", 64'(lg_drd[c0 + 3]), 64'h0);
        chk("ld_mem_we", 64'(lg_memwe[c1]), 64'h0);
        chk("ld_d_rdata", 64'(lg_drd[c1 + 3]), 64'hDEAD_BEEF);

        // starvation: both requesters held continuously
        hold_d  = 1'b1;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h8;
        if_req  = 1'b1;
        if_addr = 32'h84;
        c0 = cyc;
        run(15);
        nf = 0;
        for (int k = 0; k < 15; k++) nf += int'(lg_ifgnt[c0 + k]);
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int k = 0; k < 4; k++) chk("stv_d_gnt", 64'(lg_dgnt[c0 + 3 * k]), 64'h1);
        chk("stv_if_gnt", 64'(lg_ifgnt[c0 + 12]), 64'h1);
        chk("stv_if_gnt_count", 64'(nf), 64'h1);
`else
        chk("stv_no_if_gnt", 64'(nf), 64'h0);
`endif
        hold_d = 1'b0;
        d_req  = 1'b0;
        run(8);

        // reset mid-transaction
        if_req  = 1'b1;
        if_addr = 32'h10;
        c0 = cyc;
        run(1);
        rst_n = 1'b0;
        run(2);
        rst_n   = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h18;
        run(6);
        chk("rst_if_gnt_c0", 64'(lg_ifgnt[c0]), 64'h1);
        for (int k = 1; k <= 5; k++) chk("rst_no_rvalid", 64'(lg_ifrv[c0 + k]), 64'h0);
        chk("rst_busy_after", 64'(lg_busy[c0 + 2]), 64'h0);
        chk("rst_mem_en_after", 64'(lg_memen[c0 + 2]), 64'h0);
        chk("rst_regrant", 64'(lg_ifgnt[c0 + 3]), 64'h1);
        chk("rst_regrant_rvalid", 64'(lg_ifrv[c0 + 6]), 64'h1);

        // idle
        c0 = cyc;
        run(20);
        nf = 0;
        for (int k = 0; k < 20; k++) begin
            nf += int'(lg_memen[c0 + k]) + int'(lg_busy[c0 + k]) + int'(lg_ifgnt[c0 + k]) +
                  int'(lg_dgnt[c0 + k]) + int'(lg_ifrv[c0 + k]) + int'(lg_drv[c0 + k]);
        end
        chk("idle_activity", 64'(nf), 64'h0);

        // random traffic with abandoned requests and occasional resets
        for (int i = 0; i < 1500; i++) begin
            if (!if_req && ($urandom_range(0, 3) == 0)) begin
                if_req  = 1'b1;
                if_addr = 32'($urandom_range(0, 15) * 4);
            end else if (if_req && ($urandom_range(0, 40) == 0)) begin
                if_req = 1'b0;
            end
            if (!d_req && ($urandom_range(0, 2) == 0)) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15) * 4);
                d_wdata = $urandom;
            end else if (d_req && ($urandom_range(0, 40) == 0)) begin
                d_req = 1'b0;
            end
            rst_n = ($urandom_range(0, 299) != 0);
            run(1);
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
